// File: rtl/ysyx_23060184_ifid_queue.sv
// ysyx_23060184_ifid_queue
// Instruction queue between fetch (IFU) and decode (IDU). Each fetched
// instruction is stored with its PC and PC+4 in a small circular FIFO and is
// handed to decode through a valid/ready handshake. A front-end redirect
// (flush) discards every queued wrong-path entry plus any same-cycle enqueue.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   flush                     redirect: empty the queue next cycle
//   in_valid / in_ready       fetch-side handshake (in_ready is registered-only)
//   in_pc/in_inst/in_pcplus4  fetched payload
//   out_valid / out_ready     decode-side handshake
//   out_pc/out_inst/out_pcplus4  head payload (zero when out_valid is low)
//   count, empty, full        occupancy status
module ysyx_23060184_ifid_queue #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 2,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_inst,
  input  logic [DATA_WIDTH-1:0] in_pcplus4,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [DATA_WIDTH-1:0] out_pcplus4,
  output logic [PTR_W:0]        count,
  output logic                  empty,
  output logic                  full
);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        cnt;
  logic [DATA_WIDTH-1:0] mem_pc     [DEPTH];
  logic [DATA_WIDTH-1:0] mem_inst   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_pcplus4[DEPTH];
  logic                  enq;
  logic                  deq;

  // Status is decoded from the occupancy register only, so in_ready has no
  // combinational dependence on decode or on flush.
  assign count    = cnt;
  assign empty    = (cnt == '0);
  assign full     = (cnt == (PTR_W+1)'(DEPTH));
  assign in_ready = ~full;

  assign out_valid = ~empty & ~flush;

  // A handshake during flush completes for the IFU but its data is dropped.
  assign enq = in_valid & in_ready & ~flush;
  assign deq = out_valid & out_ready;

  always_comb begin
    out_pc      = '0;
    out_inst    = '0;
    out_pcplus4 = '0;
    if (out_valid) begin
      out_pc      = mem_pc[rd_ptr];
      out_inst    = mem_inst[rd_ptr];
      out_pcplus4 = mem_pcplus4[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq && !deq)      cnt <= cnt + (PTR_W+1)'(1);
      else if (deq && !enq) cnt <= cnt - (PTR_W+1)'(1);
    end
  end

  // Payload storage carries no reset; unused slots are never observable
  // because the output mux zeroes the head whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_pc[wr_ptr]      <= in_pc;
      mem_inst[wr_ptr]    <= in_inst;
      mem_pcplus4[wr_ptr] <= in_pcplus4;
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_ifid_queue.sv
module tb_ysyx_23060184_ifid_queue;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int PW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_pc = '0, in_inst = '0, in_pcplus4 = '0;
  logic          in_ready, out_valid, empty, full;
  logic [DW-1:0] out_pc, out_inst, out_pcplus4;
  logic [PW:0]   count;

  ysyx_23060184_ifid_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_pcplus4(in_pcplus4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_pcplus4(out_pcplus4),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] inst;
    logic [DW-1:0] p4;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the queue model for the current inputs.
  task automatic check_all();
    logic          ev;
    ent_t          h;
    ev = (q.size() != 0) && !flush;
    h  = ev ? q[0] : '0;
    chk("count",     DW'(count),     DW'(q.size()));
    chk("empty",     DW'(empty),     DW'(q.size() == 0));
    chk("full",      DW'(full),      DW'(q.size() == DEPTH));
    chk("in_ready",  DW'(in_ready),  DW'(q.size() != DEPTH));
    chk("out_valid", DW'(out_valid), DW'(ev));
    chk("out_pc",    out_pc,         h.pc);
    chk("out_inst",  out_inst,       h.inst);
    chk("out_p4",    out_pcplus4,    h.p4);
  endtask

  // One cycle: drive at negedge, check, then advance the model at posedge.
  task automatic step(input logic fl, input logic iv, input logic ordy,
                      input logic [DW-1:0] pc, input logic [DW-1:0] inst,
                      input logic [DW-1:0] p4);
    logic rdy, ov;
    @(negedge clk);
    flush = fl; in_valid = iv; out_ready = ordy;
    in_pc = pc; in_inst = inst; in_pcplus4 = p4;
    #1;
    check_all();
    rdy = (q.size() != DEPTH);
    ov  = (q.size() != 0) && !fl;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (ov && ordy) void'(q.pop_front());
      if (iv && rdy) q.push_back('{pc, inst, p4});
    end
  endtask

  task automatic enq_pc(input logic ordy, input logic [DW-1:0] pc);
    step(1'b0, 1'b1, ordy, pc, pc ^ 32'h0000_0413, pc + 32'd4);
  endtask

  logic [DW-1:0] hpc, hinst, hp4;
  logic          hiv, pend;

  initial begin
    // Reset state
    #2 check_all();
    #10 rstn = 1'b1;

    // Single pass
    step(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0413, 32'h8000_0004);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);

    // Fill/backpressure: third request held while full, then drains in order
    enq_pc(1'b0, 32'h8000_0000);
    enq_pc(1'b0, 32'h8000_0004);
    enq_pc(1'b0, 32'h8000_0008);
    enq_pc(1'b1, 32'h8000_0008);
    enq_pc(1'b1, 32'h8000_0008);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);

    // Streaming with pointer wrap
    for (int unsigned k = 0; k < 10; k++) enq_pc(1'b1, 32'h8000_0000 + 32'(4 * k));
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);

    // Flush with enqueue and dequeue requested in the same cycle
    enq_pc(1'b0, 32'h8000_0100);
    enq_pc(1'b0, 32'h8000_0104);
    step(1'b1, 1'b1, 1'b1, 32'h8000_0108, 32'h1, 32'h8000_010c);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);

    // Simultaneous enq/deq at count=1
    enq_pc(1'b0, 32'h8000_0200);
    enq_pc(1'b1, 32'h8000_0204);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Asynchronous reset mid-stream with count=2
    enq_pc(1'b0, 32'h8000_0300);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2 rstn = 1'b0;
    #1 q.delete();
    check_all();
    chk("rst_count", DW'(count), '0);
    #1 rstn = 1'b1;

    // Randomized traffic; the IFU holds its request until accepted
    pend = 1'b0;
    hiv = 1'b0; hpc = '0; hinst = '0; hp4 = '0;
    for (int unsigned i = 0; i < 400; i++) begin
      logic fl, ordy, acc;
      if (!pend) begin
        hiv   = ($urandom_range(0, 3) != 0);
        hpc   = $urandom;
        hinst = $urandom;
        hp4   = $urandom;
      end
      fl   = ($urandom_range(0, 15) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      acc  = hiv && (q.size() != DEPTH);
      step(fl, hiv, ordy, hpc, hinst, hp4);
      pend = hiv && !acc;
    end
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
